fft_output_serializer: RTL and testbench
========================================

Name: fft_output_serializer

Overview:
- Next-generation output stage of the 64-point FFT processor.
- Accepts one frame of LANES complex words in parallel from the last butterfly stage and streams them out one word per beat, lane 0 first, over a valid/ready handshake.
- Optional inverse-mode post-processing: real/imaginary interchange plus scaling.
- A one-frame pending buffer lets the upstream stage hand over the next frame while the current one drains.

Parameters:
- DATA_WIDTH, 32, complex word width; upper half = real, lower half = imaginary, two's complement; must be even.
- LANES, 8, words per frame; must be ≥ 2.
- SCALE_SHIFT, 3, arithmetic right shift applied to each half in inverse mode; must be < DATA_WIDTH/2.
- CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = forward (pass-through), 1 = inverse (swap + scale); sampled at frame acceptance.
- load_valid  input  1  parallel frame present on in_frame.
- load_ready  output  1  block can accept a frame this cycle.
- in_frame  input  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  serialized, post-processed word.
- out_index  output  clog2(LANES)  lane index of out_data.
- out_last  output  1  high with the final lane of a frame.
- frames_done  output  CNT_WIDTH  count of fully drained frames; wraps.

Behaviour:
- Reset: one clock, rst synchronous active-high; all state updates on rising clk, and rst has priority over all other inputs.
- Values after reset: state=IDLE, active and pending buffers zero, pend_full=0, out_valid=0, out_index=0, out_last=0, frames_done=0, load_ready=1.
- Reset mid-frame discards both the active and the pending frame; no further beats are emitted.
- Frame acceptance: a frame is accepted when load_valid && load_ready. load_ready = !pend_full, a registered-state function with no combinational path from out_ready.
- States: IDLE, DRAIN.
- IDLE + accept: the frame and mode go into the active buffer, index=0, next state DRAIN. First out_valid is one cycle after acceptance (latency 1).
- DRAIN + accept while pending is empty: the frame and mode go into pending, pend_full=1.
- DRAIN outputs: out_valid=1, out_index=index, out_last=(index==LANES-1).
- out_data is a combinational function of the registered active lane 0 and the latched mode.
- Non-final beat accepted (out_valid && out_ready, index<LANES-1): shift active down one lane, zero-fill the top lane, index+1.
- Final beat accepted: frames_done+1, then the first matching rule below applies:
  - pend_full: pending moves to active, pend_full=0, index=0, stay DRAIN. The next frame follows with no bubble.
  - pending empty and a load is accepted the same cycle: the new frame goes straight to active, index=0, stay DRAIN.
  - otherwise: next state IDLE, out_valid=0.
- Backpressure: while out_ready=0, out_data, out_index and out_last hold stable.
- mode changes mid-frame do not affect frames already accepted.
- Post-processing, forward (mode=0): out_data = lane word unchanged.
- Post-processing, inverse (mode=1):
  - Let H = DATA_WIDTH/2 and w = lane word.
  - Swapped word s = {w[H-1:0], w[DATA_WIDTH-1:H]}.
  - Each H-bit half of s is arithmetic-right-shifted by SCALE_SHIFT (floor, sign-extended, no rounding, no saturation).
- frames_done wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
- Reset then single forward frame (lanes = 32'h0000_0001..32'h0000_0008), out_ready=1 → 8 beats on consecutive cycles starting the cycle after acceptance; data 1..8, index 0..7, out_last only on the 8th beat; frames_done=1; state returns to IDLE.
- Inverse mode, SCALE_SHIFT=3, lane0 = 32'h0040_FF80 (real=64, imag=-128) → out_data = 32'hFFF0_0008 (real=-16, imag=8). Also lane = 32'h0007_FFF9 → 32'hFFFF_0000 (floor behaviour).
- Back-to-back frames: second frame loaded during beat 2 of the first → load_ready drops to 0 until the first frame's final beat; 16 beats with no gap; frames_done=2.
- Random out_ready backpressure (~50% duty) → out_data, out_index and out_last stable while stalled; all LANES words delivered in order; no duplicates or drops.
- Simultaneous final-beat accept and load_valid with pending empty → the new frame's lane 0 appears on the next cycle with index=0, no IDLE bubble.
- rst asserted at beat 4 of a frame with pending full → next cycle out_valid=0, frames_done=0, load_ready=1; a subsequent frame drains correctly from lane 0.

Source files
------------

// File: rtl/fft_output_serializer.sv
// Output stage of the FFT processor: takes a parallel frame of LANES complex words,
// optionally swaps/scales each word (inverse mode) and streams it out lane 0 first
// over valid/ready. One pending frame may be queued while the active one drains.
module fft_output_serializer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LANES       = 8,
    parameter int unsigned SCALE_SHIFT = 3,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_frame,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(LANES)-1:0]      out_index,
    output logic                          out_last,
    output logic [CNT_WIDTH-1:0]          frames_done
);

    localparam int unsigned IdxW  = $clog2(LANES);
    localparam int unsigned HalfW = DATA_WIDTH / 2;
    localparam int unsigned FrmW  = LANES * DATA_WIDTH;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e              state_q, state_d;
    logic [FrmW-1:0]     act_q, act_d;
    logic                act_mode_q, act_mode_d;
    logic [FrmW-1:0]     pend_q, pend_d;
    logic                pend_mode_q, pend_mode_d;
    logic                pend_full_q, pend_full_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CNT_WIDTH-1:0] frames_q, frames_d;

    logic accept;
    logic fire;
    logic is_last;

    logic [DATA_WIDTH-1:0]   lane_w;
    logic signed [HalfW-1:0] new_hi;
    logic signed [HalfW-1:0] new_lo;

    // load_ready depends only on registered state, never on out_ready
    assign load_ready  = !pend_full_q;
    assign accept      = load_valid && load_ready;
    assign out_valid   = (state_q == StDrain);
    assign fire        = out_valid && out_ready;
    assign is_last     = (idx_q == IdxW'(LANES - 1));
    assign out_index   = idx_q;
    assign out_last    = out_valid && is_last;
    assign frames_done = frames_q;

    // Post-processing of the current lane 0: swap halves, then arithmetic shift each half
    always_comb begin
        lane_w   = act_q[DATA_WIDTH-1:0];
        new_hi   = $signed(lane_w[HalfW-1:0]) >>> SCALE_SHIFT;
        new_lo   = $signed(lane_w[DATA_WIDTH-1:HalfW]) >>> SCALE_SHIFT;
        out_data = act_mode_q ? {new_hi, new_lo} : lane_w;
    end

    // Next-state logic for the drain FSM, buffers and frame counter
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        act_mode_d  = act_mode_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        frames_d    = frames_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    act_d      = in_frame;
                    act_mode_d = mode;
                    idx_d      = '0;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (fire && is_last) begin
                    frames_d = frames_q + CNT_WIDTH'(1);
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        act_mode_d  = pend_mode_q;
                        pend_full_d = 1'b0;
                        idx_d       = '0;
                    end else if (accept) begin
                        // Skip the pending buffer so the new frame follows without a bubble
                        act_d      = in_frame;
                        act_mode_d = mode;
                        idx_d      = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end else begin
                    if (fire) begin
                        act_d = act_q >> DATA_WIDTH;
                        idx_d = idx_q + IdxW'(1);
                    end
                    if (accept) begin
                        pend_d      = in_frame;
                        pend_mode_d = mode;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            act_q       <= '0;
            act_mode_q  <= 1'b0;
            pend_q      <= '0;
            pend_mode_q <= 1'b0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            act_mode_q  <= act_mode_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            frames_q    <= frames_d;
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: scoreboard of expected beats pushed on frame
// acceptance, a table of post-processing vectors, and hand-timed corner sequences.
module tb_fft_output_serializer;

    localparam int DW    = 32;
    localparam int LANES = 8;
    localparam int SH    = 3;
    localparam int CW    = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mode;
    logic                  load_valid;
    logic                  load_ready;
    logic [LANES*DW-1:0]   in_frame;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [2:0]            out_index;
    logic                  out_last;
    logic [CW-1:0]         frames_done;

    fft_output_serializer #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .SCALE_SHIFT(SH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in_frame   (in_frame),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic          m;
        logic [DW-1:0] word;
        logic [DW-1:0] exp;
    } vec_t;

    beat_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference post-processing: inverse puts imag on top, real below, each floor-divided by 8
    function automatic logic [DW-1:0] model(input logic [DW-1:0] w, input logic m);
        logic [15:0] re;
        logic [15:0] im;
        re = w[31:16];
        im = w[15:0];
        if (!m) return w;
        return {{SH{im[15]}}, im[15:SH], {SH{re[15]}}, re[15:SH]};
    endfunction

    // Monitor: scoreboard push/pop and stall-stability checks, sampled on the falling edge
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic [2:0]    held_idx;
    logic          held_last;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_index", 64'(out_index), 64'(held_idx));
                check("stall_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_index", 64'(out_index), 64'(e.idx));
                    check("sb_last", 64'(out_last), 64'(e.last));
                end
            end
            if (load_valid && load_ready) begin
                for (int i = 0; i < LANES; i++) begin
                    beat_t b;
                    b.data = model(in_frame[i*DW +: DW], mode);
                    b.idx  = 3'(i);
                    b.last = (i == LANES - 1);
                    sb.push_back(b);
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_index;
            held_last = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a frame until accepted; flip mode afterwards to show it is latched
    task automatic load_frame(input logic [LANES*DW-1:0] f, input logic m);
        int   n;
        logic ok;
        in_frame   = f;
        mode       = m;
        load_valid = 1'b1;
        n          = 0;
        do begin
            @(negedge clk);
            ok = load_ready;
            tick();
            n++;
        end while (!ok && n < 100);
        load_valid = 1'b0;
        mode       = ~m;
        if (!ok) check("load_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input logic rand_ready);
        int n;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 500) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        tick();
        if (n >= 500) check("drain_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [LANES*DW-1:0] rand_frame();
        logic [LANES*DW-1:0] f;
        for (int i = 0; i < LANES; i++) f[i*DW +: DW] = $urandom;
        return f;
    endfunction

    vec_t                vecs[7];
    logic [LANES*DW-1:0] fa;
    logic [LANES*DW-1:0] fb;
    logic [CW-1:0]       fd0;

    initial begin
        vecs[0] = '{1'b1, 32'h0040_FF80, 32'hFFF0_0008};
        vecs[1] = '{1'b1, 32'h0007_FFF9, 32'hFFFF_0000};
        vecs[2] = '{1'b0, 32'h0040_FF80, 32'h0040_FF80};
        vecs[3] = '{1'b1, 32'h8000_7FFF, 32'h0FFF_F000};
        vecs[4] = '{1'b1, 32'h1234_5678, 32'h0ACF_0246};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        rst        = 1'b1;
        mode       = 1'b0;
        load_valid = 1'b0;
        in_frame   = '0;
        out_ready  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_index", 64'(out_index), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_frames", 64'(frames_done), 64'(0));
        check("rst_ready", 64'(load_ready), 64'(1));
        tick();

        // Single forward frame, consecutive beats starting one cycle after acceptance
        for (int i = 0; i < LANES; i++) fa[i*DW +: DW] = 32'(i + 1);
        load_frame(fa, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            check("fwd_valid", 64'(out_valid), 64'(1));
            check("fwd_data", 64'(out_data), 64'(i + 1));
            check("fwd_index", 64'(out_index), 64'(i));
            check("fwd_last", 64'(out_last), 64'(i == LANES - 1));
        end
        @(negedge clk);
        check("fwd_idle", 64'(out_valid), 64'(0));
        check("fwd_frames", 64'(frames_done), 64'(1));
        tick();

        // Post-processing vector table
        foreach (vecs[k]) begin
            fa = rand_frame();
            fa[DW-1:0] = vecs[k].word;
            load_frame(fa, vecs[k].m);
            @(negedge clk);
            check("vec_data", 64'(out_data), 64'(vecs[k].exp));
            tick();
            wait_idle(1'b0);
        end

        // Back-to-back: second frame loaded during beat 2, no gap over 16 beats
        fd0 = frames_done;
        load_frame(rand_frame(), 1'b0);
        tick();
        load_frame(rand_frame(), 1'b1);
        @(negedge clk);
        check("b2b_ready_low", 64'(load_ready), 64'(0));
        check("b2b_valid", 64'(out_valid), 64'(1));
        for (int i = 3; i < 2 * LANES; i++) begin
            @(negedge clk);
            check("b2b_valid", 64'(out_valid), 64'(1));
            check("b2b_index", 64'(out_index), 64'(i % LANES));
        end
        @(negedge clk);
        check("b2b_idle", 64'(out_valid), 64'(0));
        check("b2b_frames", 64'(frames_done), 64'(fd0 + 16'd2));
        check("b2b_ready_high", 64'(load_ready), 64'(1));
        tick();

        // Random backpressure over pairs of queued frames
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b1;
            load_frame(rand_frame(), 1'($urandom_range(0, 1)));
            load_frame(rand_frame(), 1'($urandom_range(0, 1)));
            wait_idle(1'b1);
        end

        // Final beat and load in the same cycle with pending empty
        fd0 = frames_done;
        load_frame(rand_frame(), 1'b0);
        repeat (7) tick();
        fb = rand_frame();
        load_frame(fb, 1'b0);
        @(negedge clk);
        check("chain_valid", 64'(out_valid), 64'(1));
        check("chain_index", 64'(out_index), 64'(0));
        check("chain_data", 64'(out_data), 64'(fb[DW-1:0]));
        check("chain_frames", 64'(frames_done), 64'(fd0 + 16'd1));
        tick();
        wait_idle(1'b0);

        // Reset mid-frame with pending full
        load_frame(rand_frame(), 1'b1);
        load_frame(rand_frame(), 1'b0);
        repeat (3) tick();
        check("pre_rst_index", 64'(out_index), 64'(4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 64'(out_valid), 64'(0));
        check("mrst_frames", 64'(frames_done), 64'(0));
        check("mrst_ready", 64'(load_ready), 64'(1));
        check("mrst_index", 64'(out_index), 64'(0));
        tick();
        load_frame(rand_frame(), 1'b1);
        wait_idle(1'b0);
        check("post_rst_frames", 64'(frames_done), 64'(1));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
